// File: rtl/if_id_fetch.sv
// if_id_fetch: LEGv8 instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, requests instructions from imem, and fills IF/ID with either a
// fetched instruction or a NOP bubble (boot, memory wait, redirect).
// Optional macro IF_ID_PERF_CNT_EN adds saturating fetch/bubble counters.
module if_id_fetch #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h910003FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus4,
  output logic [10:0]       opcode
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, MISS} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic [ADDR_W-1:0] ifpc4_q, ifpc4_d;
  logic              load_instr;   // a real instruction is latched this cycle
  logic              load_bubble;  // a bubble is latched this cycle

  // State register, PC and IF/ID pipeline register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      ifpc4_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
    end
  end

  // Next-state and IF/ID update; priority redirect > stall > imem_ready.
  // A bubble leaves if_id_pc/pc_plus4 untouched since they are only
  // meaningful while if_id_valid is set.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    ifpc_d      = ifpc_q;
    ifpc4_d     = ifpc4_q;
    load_instr  = 1'b0;
    load_bubble = 1'b0;
    if (redirect_valid) begin
      // Redirect from any state; returned data this cycle is dropped
      pc_d        = {redirect_target[ADDR_W-1:2], 2'b00};
      load_bubble = 1'b1;
      state_d     = RUN;
    end else if (state_q == BOOT) begin
      // No request was issued while booting, so always one bubble
      load_bubble = 1'b1;
      state_d     = RUN;
    end else if (stall) begin
      // Hold everything; the same PC is refetched once the stall drops
      state_d = state_q;
    end else if (imem_ready) begin
      load_instr = 1'b1;
      pc_d       = pc_q + ADDR_W'(4);
      state_d    = RUN;
    end else begin
      load_bubble = 1'b1;
      state_d     = MISS;
    end

    if (load_instr) begin
      valid_d = 1'b1;
      instr_d = imem_rdata;
      ifpc_d  = pc_q;
      ifpc4_d = pc_q + ADDR_W'(4);
    end else if (load_bubble) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  assign imem_req       = (state_q != BOOT);
  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = ifpc4_q;
  assign opcode         = instr_q[31:21];

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] bubbles_q, bubbles_d;

  // Saturating counters for latched instructions and latched bubbles
  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (load_instr && (fetched_q != 32'hFFFF_FFFF)) fetched_d = fetched_q + 32'd1;
    if (load_bubble && (bubbles_q != 32'hFFFF_FFFF)) bubbles_d = bubbles_q + 32'd1;
  end

  // Counter registers, cleared on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_if_id_fetch.sv
// Testbench for if_id_fetch: directed scenarios followed by random stimulus,
// all checked against a behavioural model of the fetch stage.
module tb_if_id_fetch;
  localparam int unsigned ADDR_W = 64;
  localparam logic [31:0] NOP    = 32'h910003FF;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic [ADDR_W-1:0] if_id_pc_plus4;
  logic [10:0]       opcode;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]       perf_fetched;
  logic [31:0]       perf_bubbles;
`endif

  if_id_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .opcode          (opcode)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: the only hidden state that matters is "just out of reset"
  bit                m_boot;
  logic [ADDR_W-1:0] m_pc;
  bit                m_valid;
  logic [31:0]       m_instr;
  logic [ADDR_W-1:0] m_ifpc;
  logic [31:0]       m_fet;
  logic [31:0]       m_bub;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_pc = '0; m_valid = 0; m_instr = NOP; m_ifpc = '0;
    m_fet = 0; m_bub = 0;
  endtask

  task automatic check_regs();
    logic [31:0] ins;
    ins = m_instr;
    check("valid", 64'(if_id_valid), 64'(m_valid));
    check("instr", 64'(if_id_instr), 64'(ins));
    check("opcode", 64'(opcode), 64'(ins[31:21]));
    if (m_valid) begin
      check("if_id_pc", if_id_pc, m_ifpc);
      check("pc_plus4", if_id_pc_plus4, m_ifpc + 64'd4);
    end
`ifdef IF_ID_PERF_CNT_EN
    check("perf_fetched", 64'(perf_fetched), 64'(m_fet));
    check("perf_bubbles", 64'(perf_bubbles), 64'(m_bub));
`endif
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One clock: drive at negedge, check request side, advance model, check IF/ID
  task automatic cycle(input bit st, input bit rv, input logic [ADDR_W-1:0] tgt,
                       input bit rdy, input logic [31:0] rd);
    stall = st; redirect_valid = rv; redirect_target = tgt;
    imem_ready = rdy; imem_rdata = rd;
    #1;
    check("imem_req", 64'(imem_req), m_boot ? 64'd0 : 64'd1);
    check("imem_addr", imem_addr, m_pc);
    if (rv) begin
      m_pc = tgt & ~64'h3; m_valid = 0; m_instr = NOP; m_bub = sat_inc(m_bub); m_boot = 0;
    end else if (m_boot) begin
      m_valid = 0; m_instr = NOP; m_bub = sat_inc(m_bub); m_boot = 0;
    end else if (st) begin
      // everything holds
    end else if (rdy) begin
      m_valid = 1; m_instr = rd; m_ifpc = m_pc; m_pc = m_pc + 64'd4; m_fet = sat_inc(m_fet);
    end else begin
      m_valid = 0; m_instr = NOP; m_bub = sat_inc(m_bub);
    end
    @(posedge clk);
    @(negedge clk);
    $display("cyc st=%0b rv=%0b rdy=%0b -> valid=%0b instr=%08h pc=%0h next_addr=%0h",
             st, rv, rdy, if_id_valid, if_id_instr, if_id_pc, imem_addr);
    check_regs();
  endtask

  task automatic check_reset_outputs();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    check("rst_valid", 64'(if_id_valid), 64'd0);
    check("rst_instr", 64'(if_id_instr), 64'(NOP));
    check("rst_ifpc", if_id_pc, 64'd0);
    check("rst_ifpc4", if_id_pc_plus4, 64'd0);
    check("rst_opcode", 64'(opcode), 64'h488);
`ifdef IF_ID_PERF_CNT_EN
    check("rst_fetched", 64'(perf_fetched), 64'd0);
    check("rst_bubbles", 64'(perf_bubbles), 64'd0);
`endif
  endtask

  initial begin
    reset = 1; stall = 0; redirect_valid = 0; redirect_target = '0;
    imem_ready = 0; imem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    reset = 0;

    // Boot bubble then sequential fetches 0,4,8,C
    cycle(0, 0, 0, 1, 32'h8B020020);
    check("boot_opcode", 64'(opcode), 64'h488);
    cycle(0, 0, 0, 1, 32'h8B020020);
    check("first_opcode", 64'(opcode), 64'h458);
    check("first_pc", if_id_pc, 64'h0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, $urandom);

    // Three miss cycles at 0x10, then ready
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, $urandom);
    check("miss_addr", imem_addr, 64'h10);
    cycle(0, 0, 0, 1, 32'h12345678);
    check("miss_done_pc", if_id_pc, 64'h10);
    check("miss_next_addr", imem_addr, 64'h14);

    // Redirect out of MISS with stale data on the bus
    cycle(0, 0, 0, 0, $urandom);
    cycle(0, 1, 64'h103, 1, 32'hDEADBEEF);
    check("redir_addr", imem_addr, 64'h100);

    // Stall with valid IF/ID at pc 0x1C, fetching 0x20
    cycle(0, 1, 64'h1C, 0, 0);
    cycle(0, 0, 0, 1, 32'hAAAA0001);
    cycle(1, 0, 0, 1, 32'hBBBB0002);
    cycle(1, 0, 0, 1, 32'hBBBB0003);
    check("stall_ifpc", if_id_pc, 64'h1C);
    check("stall_addr", imem_addr, 64'h20);
    cycle(0, 0, 0, 1, 32'hCCCC0004);
    check("after_stall_pc", if_id_pc, 64'h20);

    // Stall and redirect together: redirect wins
    cycle(1, 1, 64'h40, 1, 32'hEEEE0005);
    check("stall_redir_valid", 64'(if_id_valid), 64'd0);
    check("stall_redir_addr", imem_addr, 64'h40);

    // PC wrap at the top of the address space
    cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    cycle(0, 0, 0, 1, 32'h0F0F0F0F);
    check("wrap_addr", imem_addr, 64'h0);

    // Random stimulus
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            {$urandom, $urandom}, ($urandom_range(0, 3) != 0), $urandom);
    end

    // Asynchronous reset in the middle of a miss
    cycle(0, 0, 0, 0, 0);
    #2 reset = 1;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clk);
    reset = 0;

    // 5 good fetches plus one redirect after reset
    cycle(0, 0, 0, 1, $urandom);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, $urandom);
    cycle(0, 1, 64'h200, 1, $urandom);
`ifdef IF_ID_PERF_CNT_EN
    check("perf5_fetched", 64'(perf_fetched), 64'd5);
    check("perf5_bubbles", 64'(perf_bubbles), 64'd2);
`endif
    check("post_reset_addr", imem_addr, 64'h200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_id_fetch.md
Name: if_id_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage LEGv8 pipeline.
- Owns the PC and issues requests to instruction memory.
- Registers the fetched instruction and its PC. Drives the 11-bit opcode slice to the ID-stage control decoder.
- Handles stall, branch redirect/flush and memory wait states, inserting bubbles as needed.

Parameters:
- ADDR_W, 64, PC and address width in bits.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h910003FF, bubble encoding (ADDI X31,X31,#0). Decodes harmlessly in the control unit.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- redirect_valid  input  1  branch resolved taken: flush and load new PC.
- redirect_target  input  ADDR_W  new PC when redirect_valid.
- imem_req  output  1  fetch request.
- imem_addr  output  ADDR_W  fetch address, always equal to the current PC.
- imem_ready  input  1  imem_rdata valid this cycle (same-cycle response to imem_req).
- imem_rdata  input  32  instruction word.
- if_id_valid  output  1  IF/ID holds a real instruction.
- if_id_instr  output  32  registered instruction (NOP_INSTR when not valid).
- if_id_pc  output  ADDR_W  PC of if_id_instr.
- if_id_pc_plus4  output  ADDR_W  if_id_pc + 4, used by BL link write.
- opcode  output  11  if_id_instr[31:21], wired to the control decoder.

Behaviour:
- Reset (async, any time, including mid-miss):
  - pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_instr=NOP_INSTR.
  - if_id_pc=0, if_id_pc_plus4=0, imem_req=0.
- States:
  - BOOT: one cycle after reset release. imem_req=0, IF/ID loads a bubble. Next state RUN.
  - RUN: imem_req=1.
    - imem_ready=1 and no stall/redirect: IF/ID<={1,imem_rdata,pc,pc+4}, pc<=pc+4, stay RUN.
    - imem_ready=0: IF/ID<=bubble, pc holds, go MISS.
  - MISS: imem_req=1 for the same pc.
    - On imem_ready: latch as in RUN, pc<=pc+4, go RUN.
    - Otherwise insert a bubble each cycle.
- Priority per cycle: reset > redirect_valid > stall > imem_ready.
- Redirect:
  - pc<=redirect_target with bits[1:0] forced to 00.
  - IF/ID<=bubble; any returned imem_rdata is discarded.
  - State goes to RUN from either RUN or MISS.
  - Redirect overrides a simultaneous stall.
- Stall (no redirect):
  - pc, IF/ID and state all hold.
  - imem_req stays asserted; data returned that cycle is discarded and the same pc is refetched after the stall drops.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; no overflow flag.
- Latency: instruction appears on if_id_* one clock after the imem_ready cycle. Redirect costs one bubble minimum.
- opcode is purely combinational from if_id_instr, so it carries NOP_INSTR[31:21]=11'b10010001000 during bubbles.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32) and perf_bubbles (32).
  - perf_fetched increments on each cycle a valid instruction is latched.
  - perf_bubbles increments on each cycle a bubble is latched (BOOT, miss, redirect).
  - Both saturate at 32'hFFFFFFFF and clear on reset; stall cycles count neither.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, imem_ready=1, rdata=0x8B020020 → cycle1 bubble (valid=0, opcode=0x488). Cycle2 valid=1, if_id_pc=0, opcode=0x458. Then pc=4,8,... each cycle.
- imem_ready low 3 cycles at pc=0x10 → three bubbles, imem_addr held at 0x10. On ready, if_id_pc=0x10, next imem_addr=0x14.
- redirect_valid with target 0x103 while in MISS → next imem_addr=0x100, IF/ID bubble, state RUN. Stale rdata never appears on if_id_instr.
- stall high 2 cycles at pc=0x20 with valid IF/ID (pc 0x1C) → if_id_pc stays 0x1C and imem_addr stays 0x20. After release, 0x20 is latched.
- stall and redirect_valid (target 0x40) same cycle → redirect wins: bubble, imem_addr=0x40.
- reset asserted mid-MISS → outputs immediately return to reset values. With IF_ID_PERF_CNT_EN, counters read 0. After 5 good fetches plus 1 redirect, perf_fetched=5 and perf_bubbles=2 (boot plus redirect).
